// File: rtl/trace_port_tx.sv
// trace_port_tx: TPIU-style continuous-mode trace transmitter; serialises bytes onto a 4-bit bus with sync/halfsync insertion.
module trace_port_tx #(
  parameter int pSYNC_PERIOD = 256,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    trace_clk,
  input  logic                    reset_n,
  input  logic                    I_enable,
  input  logic [7:0]              I_data,
  input  logic                    I_valid,
  output logic                    O_ready,
  input  logic                    I_sync_req,
  output logic [3:0]              O_trace_data,
  output logic                    O_in_sync,
  output logic                    O_idle,
  output logic [pCOUNT_WIDTH-1:0] O_sync_count
);
  localparam int CW = pSYNC_PERIOD > 0 ? $clog2(pSYNC_PERIOD + 1) : 1;
  typedef enum logic [1:0] {OFF, SYNC, DATA, IDLE} state_t;
  state_t                  state_q;
  logic [2:0]              pos_q;
  logic [3:0]              hi_q;
  logic [CW-1:0]           cnt_q;
  logic                    pend_q;
  logic [3:0]              nib_q;
  logic                    in_sync_q;
  logic                    idle_q;
  logic [pCOUNT_WIDTH-1:0] scnt_q;
  logic                    last;
  logic                    pend;
  logic                    hit;
  logic                    accept;
  logic                    go_sync;
  logic [2:0]              pos_d;
  always_comb begin
    last    = state_q == OFF || (state_q == SYNC && pos_q == 3'd7) ||
              (state_q == DATA && pos_q == 3'd1) || (state_q == IDLE && pos_q == 3'd3);
    // OFF counts as pending so that re-enabling always starts with a sync packet
    pend    = pend_q || state_q == OFF;
    hit     = pSYNC_PERIOD != 0 && cnt_q == CW'(pSYNC_PERIOD);
    O_ready = last && I_enable && !pend;
    accept  = O_ready && I_valid;
    go_sync = last && I_enable && pend;
    pos_d   = pos_q + 3'd1;
  end
  always_ff @(posedge trace_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= OFF;
      pos_q     <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b1;
      nib_q     <= '0;
      in_sync_q <= 1'b0;
      idle_q    <= 1'b0;
      scnt_q    <= '0;
    end else begin
      pend_q <= go_sync ? 1'b0 : pend || I_sync_req || hit;
      if (go_sync) begin
        cnt_q  <= '0;
        scnt_q <= scnt_q + pCOUNT_WIDTH'(1);
      end else if (accept) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (last) begin
        pos_q <= '0;
        if (!I_enable) begin
          state_q   <= OFF;
          nib_q     <= 4'h0;
          in_sync_q <= 1'b0;
          idle_q    <= 1'b0;
        end else if (pend) begin
          state_q   <= SYNC;
          nib_q     <= 4'hF;
          in_sync_q <= 1'b1;
          idle_q    <= 1'b0;
        end else if (I_valid) begin
          state_q   <= DATA;
          nib_q     <= I_data[3:0];
          hi_q      <= I_data[7:4];
          in_sync_q <= 1'b0;
          idle_q    <= 1'b0;
        end else begin
          state_q   <= IDLE;
          nib_q     <= 4'hF;
          in_sync_q <= 1'b0;
          idle_q    <= 1'b1;
        end
      end else begin
        pos_q <= pos_d;
        nib_q <= state_q == DATA ? hi_q :
                 (state_q == SYNC && pos_d == 3'd7) || (state_q == IDLE && pos_d == 3'd3) ? 4'h7 : 4'hF;
      end
    end
  end
  assign O_trace_data = nib_q;
  assign O_in_sync    = in_sync_q;
  assign O_idle       = idle_q;
  assign O_sync_count = scnt_q;
endmodule

// File: tb/tb_trace_port_tx.sv
// tb_trace_port_tx: randomized and directed bench against a nibble-queue reference model of the trace transmitter.
module tb_trace_port_tx;
  localparam int P = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        vld = 1'b0;
  logic        sreq = 1'b0;
  logic [7:0]  dat = 8'h00;
  logic        rdy;
  logic [3:0]  tdata;
  logic        in_sync;
  logic        idle;
  logic [15:0] scount;
  int          checks = 0;
  int          passes = 0;
  // model: queue of pending output beats {in_sync, idle, nibble}; empty queue means OFF
  logic [5:0]  q[$];
  bit          m_pend = 1'b1;
  int          m_cnt = 0;
  logic [15:0] m_scount = '0;
  bit          acc;
  logic [3:0]  lit_sync[8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7};
  logic [3:0]  lit_idle[4] = '{4'hF, 4'hF, 4'hF, 4'h7};
  logic [3:0]  lit_data[6] = '{4'hC, 4'h3, 4'h5, 4'hA, 4'h1, 4'h0};
  logic [7:0]  lit_bytes[3] = '{8'h3C, 8'hA5, 8'h01};
  logic [3:0]  lit_sreq[12] = '{4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [3:0]  lit_dis[4] = '{4'hA, 4'h5, 4'h0, 4'hF};

  trace_port_tx #(.pSYNC_PERIOD(P), .pCOUNT_WIDTH(16)) dut (
    .trace_clk(clk), .reset_n(rst_n), .I_enable(en), .I_data(dat), .I_valid(vld),
    .O_ready(rdy), .I_sync_req(sreq), .O_trace_data(tdata), .O_in_sync(in_sync),
    .O_idle(idle), .O_sync_count(scount));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  task automatic model_step(input logic e, input logic v, input logic [7:0] d, input logic s);
    bit bnd, pe, gs;
    bnd = q.size() <= 1;
    pe  = m_pend || q.size() == 0;
    gs  = bnd && e && pe;
    acc = bnd && e && !pe && v;
    if (q.size() > 0) void'(q.pop_front());
    if (bnd && e) begin
      if (pe) begin
        for (int i = 0; i < 8; i++) q.push_back({2'b10, lit_sync[i]});
        m_pend = 1'b0;
        m_cnt = 0;
        m_scount++;
      end else if (v) begin
        q.push_back({2'b00, d[3:0]});
        q.push_back({2'b00, d[7:4]});
        m_cnt++;
        if (P != 0 && m_cnt == P) m_pend = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) q.push_back({2'b01, lit_idle[i]});
      end
    end
    if (s && !gs) m_pend = 1'b1;
  endtask

  // called at a falling edge; returns at the next falling edge with outputs compared
  task automatic step(input logic e, input logic v, input logic [7:0] d, input logic s);
    logic [5:0] c;
    en = e; vld = v; dat = d; sreq = s;
    #1;
    chk("ready", rdy, (q.size() <= 1) && e && !(m_pend || q.size() == 0));
    model_step(e, v, d, s);
    @(negedge clk);
    c = 6'd0;
    if (q.size() > 0) c = q[0];
    chk("nibble", tdata, c[3:0]);
    chk("in_sync", in_sync, c[5]);
    chk("idle", idle, c[4]);
    chk("sync_count", scount, m_scount);
  endtask

  initial begin
    logic [7:0] tx[$];
    logic [3:0] rx[$];
    logic [7:0] cb;
    logic       cur_v;
    logic [7:0] cur_d;
    int         n;
    int         sent;
    @(negedge clk);
    chk("rst_data", tdata, 4'h0);
    chk("rst_ready", rdy, 1'b0);
    chk("rst_flags", {in_sync, idle}, 2'b00);
    chk("rst_count", scount, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'h00, 0);
      chk("lit_startup", tdata, i < 8 ? lit_sync[i] : lit_idle[i-8]);
    end
    chk("lit_count1", scount, 16'd1);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, lit_bytes[i/2], 0);
      chk("lit_stream", tdata, lit_data[i]);
    end
    n = 0;
    while (!(q.size() == 3 && q[0][4]) && n < 50) begin
      step(1, 0, 8'h00, 0);
      n++;
    end
    chk("find_idle2", q.size() == 3 && q[0][4], 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 8'h77, i == 0);
      chk("lit_sreq", tdata, lit_sreq[i]);
    end
    chk("lit_count2", scount, 16'd2);
    for (int i = 0; i < 4; i++) begin
      step(i == 0 || i == 3, i == 0, 8'h5A, 0);
      chk("lit_disable", tdata, lit_dis[i]);
    end
    chk("lit_count3", scount, 16'd3);
    n = 0;
    while (!(q.size() == 6 && q[0][5]) && n < 50) begin
      step(1, 0, 8'h00, 0);
      n++;
    end
    chk("find_sync3", q.size() == 6 && q[0][5], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", tdata, 4'h0);
    chk("async_rst_count", scount, 16'd0);
    chk("async_rst_sync", in_sync, 1'b0);
    q.delete();
    m_pend = 1'b1;
    m_cnt = 0;
    m_scount = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'h00, 0);
      chk("lit_resync", {in_sync, tdata}, {1'b1, lit_sync[i]});
    end
    sent = 0;
    n = 0;
    cb = 8'($urandom);
    while (sent < 10 && n < 200) begin
      step(1, 1, cb, 0);
      if (acc) begin
        tx.push_back(cb);
        sent++;
        cb = 8'($urandom);
      end
      if (!in_sync && !idle) rx.push_back(tdata);
      n++;
    end
    repeat (3) begin
      step(1, 0, 8'h00, 0);
      if (!in_sync && !idle) rx.push_back(tdata);
    end
    chk("stream_sent", sent, 10);
    chk("stream_count", scount, 16'd3);
    chk("stream_rx_len", rx.size(), 20);
    for (int i = 0; i < 10 && 2*i+1 < rx.size(); i++) chk("stream_byte", {rx[2*i+1], rx[2*i]}, tx[i]);
    cur_v = 1'b0;
    cur_d = 8'h00;
    repeat (1500) begin
      step($urandom_range(0, 19) != 0, cur_v, cur_d, $urandom_range(0, 39) == 0);
      if (acc || !cur_v) begin
        cur_v = $urandom_range(0, 2) != 0;
        cur_d = 8'($urandom);
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
